// File: rtl/branch_predict_resolve.sv
// EX-stage branch resolution with a bimodal 2-bit-counter BHT that fetch reads
// and EX trains, plus saturating branch and mispredict counters.
module branch_predict_resolve #(
    parameter int XLEN        = 64,
    parameter int BHT_ENTRIES = 16,
    parameter int IDX_LSB     = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  pred_pc,
    output logic             pred_taken,
    input  logic             ex_valid,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [XLEN-1:0]  ex_rs2,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_target,
    output logic             init_busy,
    output logic             resolve_valid,
    output logic             resolve_taken,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             illegal_br,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int IDX_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 state_r;
    logic [IDX_W-1:0]       init_ptr_r;
    logic [1:0]             bht_r [BHT_ENTRIES];
    logic                   init_busy_r;
    logic                   resolve_valid_r;
    logic                   resolve_taken_r;
    logic                   mispredict_r;
    logic [XLEN-1:0]        redirect_pc_r;
    logic                   illegal_br_r;
    logic [CNT_W-1:0]       br_count_r;
    logic [CNT_W-1:0]       mispred_count_r;

    logic [IDX_W-1:0]       pred_idx_s;
    logic [IDX_W-1:0]       ex_idx_s;
    logic                   legal_s;
    logic                   taken_s;
    logic                   sample_s;
    logic                   pred_taken_s;
    logic [1:0]             bht_next_s;
    logic                   unused_bits_s;

    function automatic logic br_cond(input logic [2:0] f3,
                                     input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
        case (f3)
            3'b000:  return (a == b);
            3'b001:  return (a != b);
            3'b100:  return ($signed(a) <  $signed(b));
            3'b101:  return ($signed(a) >= $signed(b));
            3'b110:  return (a <  b);
            3'b111:  return (a >= b);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] sat2_update(input logic [1:0] c, input logic up);
        if (up) begin
            return (c == 2'b11) ? 2'b11 : c + 2'b01;
        end else begin
            return (c == 2'b00) ? 2'b00 : c - 2'b01;
        end
    endfunction

    function automatic logic [CNT_W-1:0] sat_cnt_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    assign pred_idx_s    = pred_pc[IDX_LSB +: IDX_W];
    assign ex_idx_s      = ex_pc[IDX_LSB +: IDX_W];
    assign unused_bits_s = ^{pred_pc, ex_pc};

    // Decode legality, outcome and the trained counter value for the EX branch
    always_comb begin
        legal_s    = 1'b0;
        taken_s    = 1'b0;
        sample_s   = 1'b0;
        bht_next_s = bht_r[ex_idx_s];
        legal_s    = (ex_funct3 != 3'b010) && (ex_funct3 != 3'b011);
        taken_s    = legal_s && br_cond(ex_funct3, ex_rs1, ex_rs2);
        sample_s   = ex_valid && (state_r == ST_RUN);
        bht_next_s = sat2_update(bht_r[ex_idx_s], taken_s);
    end

    // Fetch-side lookup; reads the array before this cycle's training lands
    always_comb begin
        pred_taken_s = 1'b0;
        if (state_r == ST_RUN) begin
            pred_taken_s = bht_r[pred_idx_s][1];
        end else begin
            pred_taken_s = 1'b0;
        end
    end

    // Init sweep, resolution registers, BHT training and performance counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= ST_INIT;
            init_ptr_r      <= {IDX_W{1'b0}};
            init_busy_r     <= 1'b1;
            resolve_valid_r <= 1'b0;
            resolve_taken_r <= 1'b0;
            mispredict_r    <= 1'b0;
            redirect_pc_r   <= {XLEN{1'b0}};
            illegal_br_r    <= 1'b0;
            br_count_r      <= {CNT_W{1'b0}};
            mispred_count_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_INIT: begin
                    bht_r[init_ptr_r] <= 2'b01;
                    init_ptr_r        <= init_ptr_r + IDX_W'(1);
                    resolve_valid_r   <= 1'b0;
                    if (init_ptr_r == IDX_W'(BHT_ENTRIES - 1)) begin
                        state_r     <= ST_RUN;
                        init_busy_r <= 1'b0;
                    end else begin
                        state_r     <= ST_INIT;
                        init_busy_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    resolve_valid_r <= sample_s;
                    if (sample_s) begin
                        resolve_taken_r <= taken_s;
                        mispredict_r    <= taken_s ^ ex_pred_taken;
                        redirect_pc_r   <= taken_s ? ex_target : ex_pc + XLEN'(4);
                        illegal_br_r    <= ~legal_s;
                        if (legal_s) begin
                            bht_r[ex_idx_s] <= bht_next_s;
                            br_count_r      <= sat_cnt_inc(br_count_r);
                        end else begin
                            br_count_r      <= br_count_r;
                        end
                        if (taken_s ^ ex_pred_taken) begin
                            mispred_count_r <= sat_cnt_inc(mispred_count_r);
                        end else begin
                            mispred_count_r <= mispred_count_r;
                        end
                    end else begin
                        resolve_taken_r <= resolve_taken_r;
                    end
                end
                default: begin
                    state_r         <= ST_INIT;
                    init_ptr_r      <= {IDX_W{1'b0}};
                    init_busy_r     <= 1'b1;
                    resolve_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign pred_taken    = pred_taken_s;
    assign init_busy     = init_busy_r;
    assign resolve_valid = resolve_valid_r;
    assign resolve_taken = resolve_taken_r;
    assign mispredict    = mispredict_r;
    assign redirect_pc   = redirect_pc_r;
    assign illegal_br    = illegal_br_r;
    assign br_count      = br_count_r;
    assign mispred_count = mispred_count_r;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Scoreboard bench for branch_predict_resolve: random and directed branches
// against a behavioural BHT/counter model, plus a 4-bit-counter instance.
module tb_branch_predict_resolve;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] pred_pc = 64'd0;
    logic        ex_valid = 1'b0;
    logic [63:0] ex_pc = 64'd0;
    logic [2:0]  ex_funct3 = 3'd0;
    logic [63:0] ex_rs1 = 64'd0;
    logic [63:0] ex_rs2 = 64'd0;
    logic        ex_pred_taken = 1'b0;
    logic [63:0] ex_target = 64'd0;

    logic        pred_taken, init_busy, resolve_valid, resolve_taken, mispredict, illegal_br;
    logic [63:0] redirect_pc;
    logic [31:0] br_count, mispred_count;
    logic        pred_taken4, init_busy4, resolve_valid4, resolve_taken4, mispredict4, illegal_br4;
    logic [63:0] redirect_pc4;
    logic [3:0]  br_count4, mispred_count4;

    always #5 clk = ~clk;

    branch_predict_resolve u_dut (
        .clk(clk), .reset(reset), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_funct3(ex_funct3), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_pred_taken(ex_pred_taken), .ex_target(ex_target),
        .init_busy(init_busy), .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .illegal_br(illegal_br),
        .br_count(br_count), .mispred_count(mispred_count)
    );

    branch_predict_resolve #(.CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .pred_pc(pred_pc), .pred_taken(pred_taken4),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_funct3(ex_funct3), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_pred_taken(ex_pred_taken), .ex_target(ex_target),
        .init_busy(init_busy4), .resolve_valid(resolve_valid4), .resolve_taken(resolve_taken4),
        .mispredict(mispredict4), .redirect_pc(redirect_pc4), .illegal_br(illegal_br4),
        .br_count(br_count4), .mispred_count(mispred_count4)
    );

    typedef struct {
        logic        taken;
        logic        mis;
        logic [63:0] rpc;
        logic        ill;
    } exp_t;

    exp_t   expq[$];
    int     checks = 0;
    int     failures = 0;
    int     bht[N];
    int     init_left = N;
    longint brc = 0;
    longint misc = 0;
    bit     mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic cond(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int idx(input logic [63:0] pc);
        return int'((pc >> 2) & 64'hF);
    endfunction

    // Reference model: applied with the inputs present at each rising edge
    task automatic model_step();
        exp_t e;
        logic legal;
        int   i;
        if (reset) begin
            init_left = N;
            brc = 0;
            misc = 0;
            for (int k = 0; k < N; k++) bht[k] = 1;
        end else if (init_left > 0) begin
            init_left--;
        end else if (ex_valid) begin
            legal   = (ex_funct3 != 3'd2) && (ex_funct3 != 3'd3);
            e.taken = legal && cond(ex_funct3, ex_rs1, ex_rs2);
            e.mis   = e.taken ^ ex_pred_taken;
            e.rpc   = e.taken ? ex_target : ex_pc + 64'd4;
            e.ill   = !legal;
            expq.push_back(e);
            if (legal) begin
                brc++;
                i = idx(ex_pc);
                if (e.taken) bht[i] = (bht[i] == 3) ? 3 : bht[i] + 1;
                else         bht[i] = (bht[i] == 0) ? 0 : bht[i] - 1;
            end
            if (e.mis) misc++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Monitor: compares status every cycle and pops the scoreboard on results
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            chk("init_busy", {63'd0, init_busy}, {63'd0, init_left > 0});
            chk("pred_taken", {63'd0, pred_taken},
                (init_left > 0) ? 64'd0 : 64'((bht[idx(pred_pc)] >> 1) & 1));
            chk("br_count", {32'd0, br_count}, 64'(brc));
            chk("mispred_count", {32'd0, mispred_count}, 64'(misc));
            chk("br_count4", {60'd0, br_count4}, (brc > 15) ? 64'd15 : 64'(brc));
            chk("mispred_count4", {60'd0, mispred_count4}, (misc > 15) ? 64'd15 : 64'(misc));
            if (resolve_valid) begin
                if (expq.size() == 0) begin
                    chk("spurious_resolve", {63'd0, resolve_valid}, 64'd0);
                end else begin
                    e = expq.pop_front();
                    chk("resolve_taken", {63'd0, resolve_taken}, {63'd0, e.taken});
                    chk("mispredict", {63'd0, mispredict}, {63'd0, e.mis});
                    chk("redirect_pc", redirect_pc, e.rpc);
                    chk("illegal_br", {63'd0, illegal_br}, {63'd0, e.ill});
                end
            end else if (expq.size() != 0) begin
                chk("missing_resolve", {63'd0, resolve_valid}, 64'd1);
                void'(expq.pop_front());
            end
        end
    end

    task automatic br(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                      input logic pt, input logic [63:0] pc, input logic [63:0] tgt);
        ex_valid = 1'b1; ex_funct3 = f3; ex_rs1 = a; ex_rs2 = b;
        ex_pred_taken = pt; ex_pc = pc; ex_target = tgt;
        step();
    endtask

    task automatic rand_br();
        logic [63:0] a;
        ex_valid      = ($urandom_range(0, 9) < 7);
        ex_funct3     = 3'($urandom_range(0, 7));
        a             = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) a = 64'($urandom_range(0, 3));
        ex_rs1        = a;
        ex_rs2        = ($urandom_range(0, 2) == 0) ? a : {$urandom, $urandom};
        ex_pred_taken = 1'($urandom_range(0, 1));
        ex_pc         = 64'($urandom_range(0, 31)) << 2;
        if ($urandom_range(0, 7) == 0) ex_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        else if ($urandom_range(0, 3) == 0) ex_pc[63:32] = $urandom;
        ex_target     = {$urandom, $urandom};
        pred_pc       = ($urandom_range(0, 3) == 0) ? ex_pc : 64'($urandom_range(0, 31)) << 2;
        step();
    endtask

    task automatic count_init(input string name);
        int n = 0;
        while (init_busy && n < 40) begin
            rand_br();
            n++;
        end
        chk(name, 64'(n), 64'd16);
    endtask

    initial begin
        step();
        mon_en = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        count_init("init_cycles");
        ex_valid = 1'b0;
        step();

        br(3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h100, 64'h80);
        br(3'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h100, 64'h80);
        br(3'd5, 64'd5, 64'd5, 1'b1, 64'h104, 64'h200);
        br(3'd7, 64'd5, 64'd5, 1'b0, 64'h108, 64'h300);
        br(3'd1, 64'd5, 64'd5, 1'b1, 64'h10C, 64'h400);
        pred_pc = 64'h40;
        repeat (3) br(3'd0, 64'd9, 64'd9, 1'b0, 64'h40, 64'h1000);
        repeat (2) br(3'd1, 64'd9, 64'd9, 1'b1, 64'h40, 64'h1000);
        br(3'd2, 64'd1, 64'd2, 1'b1, 64'h40, 64'h1000);
        br(3'd3, 64'd1, 64'd2, 1'b0, 64'h40, 64'h1000);
        ex_valid = 1'b0;
        step();

        repeat (400) rand_br();

        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (7) rand_br();
        reset = 1'b1;
        step();
        reset = 1'b0;
        count_init("init_restart");
        repeat (60) rand_br();

        ex_valid = 1'b0;
        repeat (2) step();
        chk("queue_drained", 64'(expq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
